// File: rtl/serial_pattern_tx_if.sv
// rtl/serial_pattern_tx_if.sv - request/serial-line bundle for the serial pattern transmitter
interface serial_pattern_tx_if #(
    parameter int W = 8
);
    localparam int LW = $clog2(W + 1);

    logic          start;
    logic [W-1:0]  pattern;
    logic [LW-1:0] len;
    logic [3:0]    reps;
    logic          abort;
    logic          out;
    logic          out_valid;
    logic          busy;
    logic          done;

    // Driver side: issues requests and watches the serial line.
    modport master (
        output start, pattern, len, reps, abort,
        input  out, out_valid, busy, done
    );

    // Transmitter side.
    modport slave (
        input  start, pattern, len, reps, abort,
        output out, out_valid, busy, done
    );
endinterface

// File: rtl/serial_pattern_tx.sv
// rtl/serial_pattern_tx.sv - MSB-first serial pattern transmitter with repeat and gap insertion
module serial_pattern_tx #(
    parameter int   W        = 8,
    parameter int   GAP      = 1,
    parameter logic IDLE_LVL = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_pattern_tx_if.slave   bus
);
    localparam int              LW    = $clog2(W + 1);
    localparam logic [LW-1:0]   W_L   = LW'(W);
    localparam logic [LW-1:0]   ONE_L = LW'(1);
    localparam logic [3:0]      GAP_L = 4'(GAP);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP,
        S_DONE
    } state_t;

    state_t        state_q,     state_d;
    logic [W-1:0]  shadow_q,    shadow_d;
    logic [LW-1:0] len_q,       len_d;
    logic [LW-1:0] bitcnt_q,    bitcnt_d;
    logic [3:0]    reps_q,      reps_d;
    logic [3:0]    gapcnt_q,    gapcnt_d;
    logic          out_q,       out_d;
    logic          out_valid_q, out_valid_d;
    logic          busy_q,      busy_d;
    logic          done_q,      done_d;

    logic [LW-1:0] len_clamp;
    logic [LW-1:0] bit_idx;
    logic [W-1:0]  shifted;

    // Next-state logic; outputs are decoded from the next state so they line up with it after the edge.
    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        len_d       = len_q;
        bitcnt_d    = bitcnt_q;
        reps_d      = reps_q;
        gapcnt_d    = gapcnt_q;

        // Lengths beyond the shadow width are treated as a full-width pattern.
        len_clamp = (bus.len > W_L) ? W_L : bus.len;

        case (state_q)
            S_IDLE: begin
                // Abort takes priority over a simultaneous start.
                if (bus.start && !bus.abort) begin
                    shadow_d = bus.pattern;
                    len_d    = len_clamp;
                    reps_d   = bus.reps;
                    bitcnt_d = len_clamp;
                    gapcnt_d = 4'd0;
                    state_d  = (len_clamp == '0) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                // bitcnt_q holds (index + 1) of the bit currently on the line.
                if (bitcnt_q > ONE_L) begin
                    bitcnt_d = bitcnt_q - ONE_L;
                end else if (reps_q != 4'd0) begin
                    reps_d   = reps_q - 4'd1;
                    bitcnt_d = len_q;
                    if (GAP_L == 4'd0) begin
                        state_d = S_SHIFT;
                    end else begin
                        state_d  = S_GAP;
                        gapcnt_d = GAP_L;
                    end
                end else begin
                    bitcnt_d = '0;
                    state_d  = S_DONE;
                end
            end
            S_GAP: begin
                if (gapcnt_q > 4'd1) begin
                    gapcnt_d = gapcnt_q - 4'd1;
                end else begin
                    gapcnt_d = 4'd0;
                    state_d  = S_SHIFT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (bus.abort && (state_q != S_IDLE)) begin
            state_d  = S_IDLE;
            bitcnt_d = '0;
            reps_d   = 4'd0;
            gapcnt_d = 4'd0;
        end

        bit_idx = bitcnt_d - ONE_L;
        shifted = shadow_d >> bit_idx;

        out_d       = IDLE_LVL;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        case (state_d)
            S_SHIFT: begin
                out_d       = shifted[0];
                out_valid_d = 1'b1;
                busy_d      = 1'b1;
            end
            S_GAP: begin
                busy_d = 1'b1;
            end
            S_DONE: begin
                busy_d = 1'b1;
                done_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // State, shadow copy, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            shadow_q    <= '0;
            len_q       <= '0;
            bitcnt_q    <= '0;
            reps_q      <= 4'd0;
            gapcnt_q    <= 4'd0;
            out_q       <= IDLE_LVL;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            len_q       <= len_d;
            bitcnt_q    <= bitcnt_d;
            reps_q      <= reps_d;
            gapcnt_q    <= gapcnt_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_serial_pattern_tx.sv
// tb/tb_serial_pattern_tx.sv - scoreboard bench for serial_pattern_tx
module tb_serial_pattern_tx;
    localparam int   W        = 8;
    localparam int   LW       = $clog2(W + 1);
    localparam int   GAP      = 1;
    localparam logic IDLE_LVL = 1'b1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    serial_pattern_tx_if #(.W(W)) bus();

    serial_pattern_tx #(.W(W), .GAP(GAP), .IDLE_LVL(IDLE_LVL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Per-cycle expectation: {out_valid, out, busy, done}
    logic [3:0] exp_q[$];
    localparam logic [3:0] IDLE_V = {1'b0, IDLE_LVL, 1'b0, 1'b0};
    localparam logic [3:0] GAP_V  = {1'b0, IDLE_LVL, 1'b1, 1'b0};
    localparam logic [3:0] DONE_V = {1'b0, IDLE_LVL, 1'b1, 1'b1};

    function automatic logic [3:0] observe();
        return {bus.out_valid, bus.out, bus.busy, bus.done};
    endfunction

    // Expected line behaviour from the cycle after acceptance through the first idle cycle.
    function automatic void push_model(logic [W-1:0] pat, int len, int reps);
        int l;
        l = (len > W) ? W : len;
        if (l != 0) begin
            for (int r = 0; r <= reps; r++) begin
                for (int i = l - 1; i >= 0; i--)
                    exp_q.push_back({1'b1, pat[i], 1'b1, 1'b0});
                if (r < reps)
                    for (int g = 0; g < GAP; g++) exp_q.push_back(GAP_V);
            end
        end
        exp_q.push_back(DONE_V);
        exp_q.push_back(IDLE_V);
    endfunction

    // Present a request for one cycle, then scramble the inputs to show they are not re-read.
    task automatic send_start(logic [W-1:0] pat, int len, int reps);
        bus.start   = 1'b1;
        bus.pattern = pat;
        bus.len     = LW'(len);
        bus.reps    = 4'(reps);
        @(posedge clk); #1;
        bus.start   = 1'b0;
        bus.pattern = ~pat;
        bus.len     = LW'($urandom);
        bus.reps    = 4'($urandom);
    endtask

    task automatic test_reset();
        logic [3:0] obs;
        rst = 1'b1;
        bus.start = 1'b0; bus.abort = 1'b0; bus.pattern = '0; bus.len = '0; bus.reps = 4'd0;
        #2;
        obs = observe(); checks++;
        if (obs !== IDLE_V) begin failures++; $display("FAIL reset_async got=%b exp=%b", obs, IDLE_V); end
        repeat (2) @(posedge clk);
        #1;
        obs = observe(); checks++;
        if (obs !== IDLE_V) begin failures++; $display("FAIL reset_held got=%b exp=%b", obs, IDLE_V); end
        rst = 1'b0;
        @(posedge clk); #1;
        obs = observe(); checks++;
        if (obs !== IDLE_V) begin failures++; $display("FAIL reset_release got=%b exp=%b", obs, IDLE_V); end
    endtask

    task automatic test_single();
        logic [3:0] obs, e;
        int cyc;
        send_start(8'hB2, 8, 0);
        push_model(8'hB2, 8, 0);
        cyc = 0;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); obs = observe(); checks++;
            if (obs !== e) begin failures++; $display("FAIL single cyc=%0d got=%b exp=%b", cyc, obs, e); end
            cyc++;
            if (exp_q.size() != 0) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_repeats();
        logic [3:0] obs, e;
        int cyc;
        send_start(8'h05, 3, 2);
        push_model(8'h05, 3, 2);
        cyc = 0;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); obs = observe(); checks++;
            if (obs !== e) begin failures++; $display("FAIL repeats cyc=%0d got=%b exp=%b", cyc, obs, e); end
            cyc++;
            if (exp_q.size() != 0) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_boundary();
        logic [3:0] obs, e;
        int cyc;
        logic [W-1:0] pats [4] = '{8'hAA, 8'hA5, 8'hFE, 8'h09};
        int lens [4] = '{0, 12, 1, 4};
        int repv [4] = '{0, 0, 0, 15};
        for (int t = 0; t < 4; t++) begin
            send_start(pats[t], lens[t], repv[t]);
            push_model(pats[t], lens[t], repv[t]);
            cyc = 0;
            while (exp_q.size() != 0) begin
                e = exp_q.pop_front(); obs = observe(); checks++;
                if (obs !== e) begin
                    failures++;
                    $display("FAIL boundary len=%0d reps=%0d cyc=%0d got=%b exp=%b", lens[t], repv[t], cyc, obs, e);
                end
                cyc++;
                if (exp_q.size() != 0) begin @(posedge clk); #1; end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] obs, e;
        int cyc;
        // Each request is raised in the first idle cycle after the previous DONE.
        for (int t = 0; t < 3; t++) begin
            send_start(8'(8'h5A + 8'(t * 37)), 5 + t, t);
            push_model(8'(8'h5A + 8'(t * 37)), 5 + t, t);
            cyc = 0;
            while (exp_q.size() != 0) begin
                e = exp_q.pop_front(); obs = observe(); checks++;
                if (obs !== e) begin failures++; $display("FAIL back_to_back t=%0d cyc=%0d got=%b exp=%b", t, cyc, obs, e); end
                cyc++;
                if (exp_q.size() != 0) begin @(posedge clk); #1; end
            end
        end
    endtask

    task automatic test_abort();
        logic [3:0] obs, e;
        int cyc;
        send_start(8'hB2, 8, 0);
        push_model(8'hB2, 8, 0);
        for (cyc = 0; cyc < 4; cyc++) begin
            e = exp_q.pop_front(); obs = observe(); checks++;
            if (obs !== e) begin failures++; $display("FAIL abort_prefix cyc=%0d got=%b exp=%b", cyc, obs, e); end
            if (cyc < 3) begin @(posedge clk); #1; end
        end
        exp_q.delete();
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        obs = observe(); checks++;
        if (obs !== IDLE_V) begin failures++; $display("FAIL abort_cut got=%b exp=%b", obs, IDLE_V); end
        send_start(8'h6D, 5, 1);
        push_model(8'h6D, 5, 1);
        cyc = 0;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); obs = observe(); checks++;
            if (obs !== e) begin failures++; $display("FAIL abort_restart cyc=%0d got=%b exp=%b", cyc, obs, e); end
            cyc++;
            if (exp_q.size() != 0) begin @(posedge clk); #1; end
        end
        // Abort together with start in IDLE drops the request.
        bus.start = 1'b1; bus.abort = 1'b1; bus.pattern = 8'hC3; bus.len = LW'(8); bus.reps = 4'd0;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.abort = 1'b0;
        for (cyc = 0; cyc < 3; cyc++) begin
            obs = observe(); checks++;
            if (obs !== IDLE_V) begin failures++; $display("FAIL abort_start cyc=%0d got=%b exp=%b", cyc, obs, IDLE_V); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_start_while_busy();
        logic [3:0] obs, e;
        int cyc;
        send_start(8'h00, 8, 0);
        push_model(8'h00, 8, 0);
        exp_q.push_back(IDLE_V);
        exp_q.push_back(IDLE_V);
        cyc = 0;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); obs = observe(); checks++;
            if (obs !== e) begin failures++; $display("FAIL start_busy cyc=%0d got=%b exp=%b", cyc, obs, e); end
            // Stray requests mid-shift and during the DONE cycle.
            if (cyc == 3 || cyc == 8) begin
                bus.start = 1'b1; bus.pattern = 8'hFF; bus.len = LW'(8); bus.reps = 4'd0;
            end else begin
                bus.start = 1'b0;
            end
            cyc++;
            if (exp_q.size() != 0) begin @(posedge clk); #1; end
        end
        bus.start = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [3:0] obs, e;
        int cyc;
        send_start(8'hB2, 8, 3);
        push_model(8'hB2, 8, 3);
        for (cyc = 0; cyc < 3; cyc++) begin
            e = exp_q.pop_front(); obs = observe(); checks++;
            if (obs !== e) begin failures++; $display("FAIL areset_prefix cyc=%0d got=%b exp=%b", cyc, obs, e); end
            if (cyc < 2) begin @(posedge clk); #1; end
        end
        exp_q.delete();
        #2 rst = 1'b1;
        #1;
        obs = observe(); checks++;
        if (obs !== IDLE_V) begin failures++; $display("FAIL areset_immediate got=%b exp=%b", obs, IDLE_V); end
        #2 rst = 1'b0;
        for (cyc = 0; cyc < 4; cyc++) begin
            @(posedge clk); #1;
            obs = observe(); checks++;
            if (obs !== IDLE_V) begin failures++; $display("FAIL areset_idle cyc=%0d got=%b exp=%b", cyc, obs, IDLE_V); end
        end
        send_start(8'h3C, 6, 0);
        push_model(8'h3C, 6, 0);
        cyc = 0;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); obs = observe(); checks++;
            if (obs !== e) begin failures++; $display("FAIL areset_after cyc=%0d got=%b exp=%b", cyc, obs, e); end
            cyc++;
            if (exp_q.size() != 0) begin @(posedge clk); #1; end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_repeats();
        test_boundary();
        test_back_to_back();
        test_abort();
        test_start_while_busy();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
